minesweeper_ctrl: RTL and testbench

Parametrised game controller for the minesweeper board. It sits between the debounced button pulses and the board memory. It moves the cursor with wrap-around, toggles flags against a flag budget, reveals cells, and detects loss and win. It also supports restart without a global reset.

---
 rtl/minesweeper_ctrl.sv | 154 +++++++++++++++
 tb/tb_minesweeper_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minesweeper_ctrl.sv
// Minesweeper game controller: moves the cursor, toggles flags against the mine budget,
// reveals cells and tracks loss and win between the debounced buttons and board memory.
module minesweeper_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int MINES = 10,
    parameter int RW    = $clog2(ROWS),
    parameter int CW    = $clog2(COLS),
    parameter int NW    = $clog2(ROWS*COLS+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          board_ready,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_reveal,
    input  logic          btn_flag,
    input  logic          cell_mine,
    input  logic          cell_flag,
    input  logic          cell_open,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic          wr_en,
    output logic          wr_flag,
    output logic          wr_open,
    output logic [NW-1:0] flags_left,
    output logic [NW-1:0] opened,
    output logic          busy,
    output logic          game_over,
    output logic          win
);

    // state | meaning
    // IDLE  | waiting for board loader
    // PLAY  | accepting buttons
    // MOVE  | stepping cursor in latched direction
    // FLAG  | toggling flag at cursor
    // CHECK | deciding what a reveal does
    // OPEN  | opening a safe cell
    // LOSE  | mine revealed, waits for restart
    // WIN   | all safe cells opened, waits for restart
    typedef enum logic [2:0] {
        S_IDLE, S_PLAY, S_MOVE, S_FLAG, S_CHECK, S_OPEN, S_LOSE, S_WIN
    } state_t;

    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    localparam logic [NW-1:0] SAFE_N  = NW'(ROWS*COLS - MINES);
    localparam logic [NW-1:0] MINES_N = NW'(MINES);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    state_t state;
    dir_t   dir;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            dir        <= D_UP;
            cur_row    <= '0;
            cur_col    <= '0;
            flags_left <= MINES_N;
            opened     <= '0;
        end else begin
            case (state)
                S_IDLE: if (board_ready) state <= S_PLAY;
                S_PLAY: begin
                    if (btn_reveal) begin
                        state <= S_CHECK;
                    end else if (btn_flag) begin
                        state <= S_FLAG;
                    end else if (btn_up || btn_down || btn_left || btn_right) begin
                        state <= S_MOVE;
                        if (btn_up)        dir <= D_UP;
                        else if (btn_down) dir <= D_DOWN;
                        else if (btn_left) dir <= D_LEFT;
                        else               dir <= D_RIGHT;
                    end
                end
                S_MOVE: begin
                    case (dir)
                        D_UP:    cur_row <= (cur_row == '0)      ? ROW_MAX : cur_row - RW'(1);
                        D_DOWN:  cur_row <= (cur_row == ROW_MAX) ? '0      : cur_row + RW'(1);
                        D_LEFT:  cur_col <= (cur_col == '0)      ? COL_MAX : cur_col - CW'(1);
                        default: cur_col <= (cur_col == COL_MAX) ? '0      : cur_col + CW'(1);
                    endcase
                    state <= S_PLAY;
                end
                S_FLAG: begin
                    if (!cell_open) begin
                        if (cell_flag) begin
                            if (flags_left < MINES_N) flags_left <= flags_left + NW'(1);
                        end else if (flags_left != '0) begin
                            flags_left <= flags_left - NW'(1);
                        end
                    end
                    state <= S_PLAY;
                end
                S_CHECK: begin
                    if (cell_open || cell_flag) state <= S_PLAY;
                    else if (cell_mine)         state <= S_LOSE;
                    else                        state <= S_OPEN;
                end
                S_OPEN: begin
                    if (opened < SAFE_N) opened <= opened + NW'(1);
                    state <= (opened + NW'(1) == SAFE_N) ? S_WIN : S_PLAY;
                end
                S_LOSE, S_WIN: begin
                    if (btn_reveal) begin
                        state      <= S_IDLE;
                        cur_row    <= '0;
                        cur_col    <= '0;
                        flags_left <= MINES_N;
                        opened     <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write strobes are gated by rst so no board write escapes on a reset edge.
    always_comb begin
        wr_en   = 1'b0;
        wr_flag = 1'b0;
        wr_open = 1'b0;
        if (rst) begin
            case (state)
                S_FLAG: begin
                    if (!cell_open) begin
                        if (cell_flag) begin
                            wr_en = 1'b1;
                        end else if (flags_left != '0) begin
                            wr_en   = 1'b1;
                            wr_flag = 1'b1;
                        end
                    end
                end
                S_OPEN: begin
                    wr_en   = 1'b1;
                    wr_open = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_PLAY);
    assign game_over = (state == S_LOSE);
    assign win       = (state == S_WIN);

endmodule

// File: tb/tb_minesweeper_ctrl.sv
// Directed bench for minesweeper_ctrl: an 8x8/10-mine instance and a 2x2/1-mine instance,
// each backed by a small board memory model; buttons are shared, instances are reset in turn.
module tb_minesweeper_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, board_ready;
    logic btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag;

    logic [2:0] cur_row_a, cur_col_a;
    logic [6:0] flags_left_a, opened_a;
    logic       wr_en_a, wr_flag_a, wr_open_a, busy_a, game_over_a, win_a;
    logic       cell_mine_a, cell_flag_a, cell_open_a;

    logic [0:0] cur_row_b, cur_col_b;
    logic [2:0] flags_left_b, opened_b;
    logic       wr_en_b, wr_flag_b, wr_open_b, busy_b, game_over_b, win_b;
    logic       cell_mine_b, cell_flag_b, cell_open_b;

    minesweeper_ctrl u_a (
        .clk(clk), .rst(rst_a), .board_ready(board_ready),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_reveal(btn_reveal), .btn_flag(btn_flag),
        .cell_mine(cell_mine_a), .cell_flag(cell_flag_a), .cell_open(cell_open_a),
        .cur_row(cur_row_a), .cur_col(cur_col_a),
        .wr_en(wr_en_a), .wr_flag(wr_flag_a), .wr_open(wr_open_a),
        .flags_left(flags_left_a), .opened(opened_a),
        .busy(busy_a), .game_over(game_over_a), .win(win_a)
    );

    minesweeper_ctrl #(.ROWS(2), .COLS(2), .MINES(1)) u_b (
        .clk(clk), .rst(rst_b), .board_ready(board_ready),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_reveal(btn_reveal), .btn_flag(btn_flag),
        .cell_mine(cell_mine_b), .cell_flag(cell_flag_b), .cell_open(cell_open_b),
        .cur_row(cur_row_b), .cur_col(cur_col_b),
        .wr_en(wr_en_b), .wr_flag(wr_flag_b), .wr_open(wr_open_b),
        .flags_left(flags_left_b), .opened(opened_b),
        .busy(busy_b), .game_over(game_over_b), .win(win_b)
    );

    // Board memories: mine at (2,1) on the 8x8 board, at (1,1) on the 2x2 board.
    logic [63:0] mine_a, flag_a, open_a;
    logic [5:0]  idx_a;
    logic [3:0]  mine_b, flag_b, open_b;
    logic [1:0]  idx_b;
    int          wr_cnt_a, wr1_cnt_a;

    assign mine_a      = 64'h0000_0000_0002_0000;
    assign idx_a       = {cur_row_a, cur_col_a};
    assign cell_mine_a = mine_a[idx_a];
    assign cell_flag_a = flag_a[idx_a];
    assign cell_open_a = open_a[idx_a];
    assign mine_b      = 4'b1000;
    assign idx_b       = {cur_row_b, cur_col_b};
    assign cell_mine_b = mine_b[idx_b];
    assign cell_flag_b = flag_b[idx_b];
    assign cell_open_b = open_b[idx_b];

    always @(posedge clk) begin
        if (!rst_a) begin
            flag_a    <= '0;
            open_a    <= '0;
            wr_cnt_a  <= 0;
            wr1_cnt_a <= 0;
        end else if (wr_en_a) begin
            flag_a[idx_a] <= wr_flag_a;
            open_a[idx_a] <= wr_open_a;
            wr_cnt_a      <= wr_cnt_a + 1;
            if (wr_flag_a) wr1_cnt_a <= wr1_cnt_a + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst_b) begin
            flag_b <= '0;
            open_b <= '0;
        end else if (wr_en_b) begin
            flag_b[idx_b] <= wr_flag_b;
            open_b[idx_b] <= wr_open_b;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_btns();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_reveal = 0; btn_flag = 0;
    endtask

    // d: 0 up, 1 down, 2 left, 3 right
    task automatic move(input int d);
        case (d)
            0: btn_up = 1;
            1: btn_down = 1;
            2: btn_left = 1;
            default: btn_right = 1;
        endcase
        tick();
        clear_btns();
        tick();
    endtask

    // Leaves the instance in FLAG / CHECK respectively.
    task automatic press_flag();
        btn_flag = 1;
        tick();
        btn_flag = 0;
    endtask

    task automatic press_reveal();
        btn_reveal = 1;
        tick();
        btn_reveal = 0;
    endtask

    int w0;

    initial begin
        rst_a = 0; rst_b = 0; board_ready = 0;
        clear_btns();
        tick(); tick();
        check("rst_row",    32'(cur_row_a), 0);
        check("rst_col",    32'(cur_col_a), 0);
        check("rst_flags",  32'(flags_left_a), 10);
        check("rst_opened", 32'(opened_a), 0);
        check("rst_busy",   32'(busy_a), 1);
        check("rst_wr_en",  32'(wr_en_a), 0);
        check("rst_over",   32'(game_over_a), 0);
        check("rst_win",    32'(win_a), 0);

        rst_a = 1;
        btn_up = 1; tick(); clear_btns(); tick();
        check("idle_busy", 32'(busy_a), 1);
        check("idle_btn",  32'(cur_row_a), 0);
        board_ready = 1; tick();
        check("play_busy", 32'(busy_a), 0);

        move(0);
        check("up_wrap_row", 32'(cur_row_a), 7);
        check("up_wrap_col", 32'(cur_col_a), 0);
        move(2);
        check("left_wrap", 32'(cur_col_a), 7);
        move(3);
        check("right_wrap", 32'(cur_col_a), 0);
        move(1);
        check("down_wrap", 32'(cur_row_a), 0);
        btn_up = 1; btn_down = 1; btn_left = 1; tick(); clear_btns(); tick();
        check("dir_prio_row", 32'(cur_row_a), 7);
        check("dir_prio_col", 32'(cur_col_a), 0);
        move(1);

        btn_right = 1; tick();
        btn_right = 0; btn_flag = 1;
        check("move_busy", 32'(busy_a), 1);
        tick(); btn_flag = 0; tick();
        check("drop_col",   32'(cur_col_a), 1);
        check("drop_flags", 32'(flags_left_a), 10);
        move(2);

        for (int i = 0; i < 10; i++) begin
            press_flag();
            check("flag_wr_en", 32'(wr_en_a), 1);
            check("flag_wr_v",  32'(wr_flag_a), 1);
            tick();
            move(3);
            if (i == 7) move(1);
        end
        check("budget_flags", 32'(flags_left_a), 0);
        check("budget_wr",    32'(wr1_cnt_a), 10);
        press_flag();
        check("over_wr_en", 32'(wr_en_a), 0);
        tick();
        check("over_flags", 32'(flags_left_a), 0);
        check("over_wr",    32'(wr_cnt_a), 10);
        move(2);
        press_flag();
        check("unflag_wr_en", 32'(wr_en_a), 1);
        check("unflag_wr_v",  32'(wr_flag_a), 0);
        tick();
        check("unflag_flags", 32'(flags_left_a), 1);

        move(2);
        press_reveal();
        check("rev_flag_chk_wr", 32'(wr_en_a), 0);
        tick();
        check("rev_flag_busy",   32'(busy_a), 0);
        check("rev_flag_opened", 32'(opened_a), 0);

        move(3);
        btn_reveal = 1; btn_flag = 1; btn_up = 1; tick(); clear_btns();
        check("combo_chk_wr", 32'(wr_en_a), 0);
        tick();
        check("open_wr_en",   32'(wr_en_a), 1);
        check("open_wr_open", 32'(wr_open_a), 1);
        check("open_wr_flag", 32'(wr_flag_a), 0);
        tick();
        check("combo_row",    32'(cur_row_a), 1);
        check("combo_col",    32'(cur_col_a), 1);
        check("combo_flags",  32'(flags_left_a), 1);
        check("combo_opened", 32'(opened_a), 1);

        press_reveal(); tick();
        check("rev_open_opened", 32'(opened_a), 1);
        check("rev_open_busy",   32'(busy_a), 0);
        press_flag();
        check("flag_open_wr", 32'(wr_en_a), 0);
        tick();
        check("flag_open_flags", 32'(flags_left_a), 1);

        move(1);
        press_reveal();
        check("mine_chk_wr",   32'(wr_en_a), 0);
        check("mine_chk_over", 32'(game_over_a), 0);
        tick();
        check("lose_over", 32'(game_over_a), 1);
        check("lose_busy", 32'(busy_a), 1);
        check("lose_wr",   32'(wr_en_a), 0);
        w0 = wr_cnt_a;
        btn_down = 1; tick(); btn_down = 0;
        btn_flag = 1; tick(); btn_flag = 0; tick();
        check("lose_row",   32'(cur_row_a), 2);
        check("lose_col",   32'(cur_col_a), 1);
        check("lose_nowr",  32'(wr_cnt_a), 32'(w0));
        check("lose_stick", 32'(game_over_a), 1);
        press_reveal();
        check("lrst_busy",   32'(busy_a), 1);
        check("lrst_over",   32'(game_over_a), 0);
        check("lrst_flags",  32'(flags_left_a), 10);
        check("lrst_opened", 32'(opened_a), 0);
        check("lrst_row",    32'(cur_row_a), 0);
        check("lrst_col",    32'(cur_col_a), 0);
        tick();

        move(0);
        press_reveal(); tick();
        check("pre_rst_wr", 32'(wr_en_a), 1);
        rst_a = 0; #1;
        check("rst_open_wr", 32'(wr_en_a), 0);
        tick();
        check("rst_open_busy",   32'(busy_a), 1);
        check("rst_open_opened", 32'(opened_a), 0);
        check("rst_open_row",    32'(cur_row_a), 0);

        rst_b = 1; tick();
        check("b_play", 32'(busy_b), 0);
        press_reveal(); tick();
        check("b_open1_wr", 32'(wr_open_b), 1);
        tick();
        check("b_opened1", 32'(opened_b), 1);
        move(3);
        press_reveal(); tick();
        check("b_open2_wr", 32'(wr_open_b), 1);
        tick();
        check("b_opened2", 32'(opened_b), 2);
        check("b_nowin2",  32'(win_b), 0);
        move(2); move(1);
        press_reveal(); tick();
        check("b_open3_wr", 32'(wr_open_b), 1);
        tick();
        check("b_opened3", 32'(opened_b), 3);
        check("b_win",     32'(win_b), 1);
        check("b_win_busy", 32'(busy_b), 1);
        btn_up = 1; tick(); clear_btns(); tick();
        check("b_win_row", 32'(cur_row_b), 1);
        press_reveal();
        check("b_rst_win",    32'(win_b), 0);
        check("b_rst_busy",   32'(busy_b), 1);
        check("b_rst_flags",  32'(flags_left_b), 1);
        check("b_rst_opened", 32'(opened_b), 0);
        check("b_rst_row",    32'(cur_row_b), 0);
        check("b_rst_col",    32'(cur_col_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
